// File: rtl/decryption_demux.sv
// decryption_demux: buffers the incoming character stream and forwards each
// message, terminated by the start token, to one of three decryption engines.
module decryption_demux #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 FIFO_DEPTH             = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         select,
  input  logic [2:0]         busy_i,
  output logic               ready_o,
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o,
  output logic               overflow_o,
  output logic               trunc_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FWD, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_n;
  logic [D_WIDTH+1:0] mem [FIFO_DEPTH];
  logic [D_WIDTH+1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] cur_sel, cur_sel_n, head_sel, wait_cnt, wait_cnt_n;
  logic [7:0] char_cnt, char_cnt_n;
  logic [D_WIDTH-1:0] head_data, out_data;
  logic [3:0] busy_x;
  logic empty, push, pop, out_en, trunc_set;
  assign ready_o = !count[AW];
  assign empty = count == '0;
  assign push = valid_i && ready_o;
  assign head = mem[rd_ptr];
  assign head_sel = head[D_WIDTH+1:D_WIDTH];
  assign head_data = head[D_WIDTH-1:0];
  // the discard channel never reports idle, so it is handled explicitly
  assign busy_x = {1'b1, busy_i};
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {select, data_i};
  always_comb begin
    state_n = state;
    cur_sel_n = cur_sel;
    char_cnt_n = char_cnt;
    wait_cnt_n = wait_cnt;
    pop = 1'b0;
    out_en = 1'b0;
    out_data = '0;
    trunc_set = 1'b0;
    case (state)
      IDLE:
        if (!empty && (head_sel == 2'd3 || !busy_x[head_sel])) begin
          state_n = FWD;
          cur_sel_n = head_sel;
          char_cnt_n = '0;
        end
      FWD:
        if (cur_sel != 2'd3 && char_cnt == 8'(MAX_NOF_CHARS)) begin
          out_en = 1'b1;
          out_data = START_DECRYPTION_TOKEN;
          trunc_set = 1'b1;
          state_n = WAIT_HI;
          wait_cnt_n = '0;
        end else if (!empty) begin
          pop = 1'b1;
          out_en = cur_sel != 2'd3;
          out_data = head_data;
          if (head_data == START_DECRYPTION_TOKEN) begin
            state_n = cur_sel == 2'd3 ? IDLE : WAIT_HI;
            wait_cnt_n = '0;
          end else
            char_cnt_n = char_cnt == 8'hFF ? char_cnt : char_cnt + 8'd1;
        end
      WAIT_HI:
        if (busy_x[cur_sel]) state_n = WAIT_LO;
        else if (wait_cnt == 2'd3) state_n = IDLE;
        else wait_cnt_n = wait_cnt + 2'd1;
      WAIT_LO:
        if (!busy_x[cur_sel]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cur_sel <= '0;
      char_cnt <= '0;
      wait_cnt <= '0;
      data0_o <= '0;
      data1_o <= '0;
      data2_o <= '0;
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
      overflow_o <= 1'b0;
      trunc_o <= 1'b0;
    end else begin
      state <= state_n;
      cur_sel <= cur_sel_n;
      char_cnt <= char_cnt_n;
      wait_cnt <= wait_cnt_n;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      valid0_o <= out_en && cur_sel == 2'd0;
      valid1_o <= out_en && cur_sel == 2'd1;
      valid2_o <= out_en && cur_sel == 2'd2;
      data0_o <= out_en && cur_sel == 2'd0 ? out_data : '0;
      data1_o <= out_en && cur_sel == 2'd1 ? out_data : '0;
      data2_o <= out_en && cur_sel == 2'd2 ? out_data : '0;
      overflow_o <= overflow_o || (valid_i && !ready_o);
      trunc_o <= trunc_o || trunc_set;
    end
  end
endmodule

// File: tb/tb_decryption_demux.sv
// tb_decryption_demux: directed stimulus against a message-level routing model
// with simple engine models that raise busy after each token.
module tb_decryption_demux;
  localparam logic [7:0] TOK = 8'hFA;
  logic clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0;
  logic [7:0] data_i = '0;
  logic [1:0] select = '0;
  logic [2:0] busy_i, busy_eng = '0, busy_force = '0;
  logic ready_o, valid0_o, valid1_o, valid2_o, overflow_o, trunc_o;
  logic [7:0] data0_o, data1_o, data2_o;
  int checks = 0, errors = 0, cyc = 0, busy_len = 3, t0;
  int fall_cyc [3];
  logic [7:0] q0 [$], q1 [$], q2 [$];
  typedef struct {int cyc; int ch; logic [7:0] d;} ent_t;
  ent_t log_q [$];
  logic in_msg = 1'b0, exp_ovf = 1'b0, exp_trunc = 1'b0;
  logic [1:0] msg_sel = '0;
  int cnt = 0;
  assign busy_i = busy_eng | busy_force;

  decryption_demux dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .select(select),
    .busy_i(busy_i), .ready_o(ready_o), .data0_o(data0_o), .data1_o(data1_o),
    .data2_o(data2_o), .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o),
    .overflow_o(overflow_o), .trunc_o(trunc_o)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int ch, input logic [7:0] b);
    if (ch == 0) q0.push_back(b);
    else if (ch == 1) q1.push_back(b);
    else q2.push_back(b);
  endtask

  // message-level model: a message goes to its head byte's select, is cut
  // after MAX_NOF_CHARS characters by an extra token, and select 3 is dropped
  task automatic model_push(input logic [7:0] b, input logic [1:0] s);
    if (!in_msg) begin
      in_msg = 1'b1;
      msg_sel = s;
      cnt = 0;
    end
    if (b == TOK) begin
      if (msg_sel != 2'd3) exp_push(int'(msg_sel), TOK);
      in_msg = 1'b0;
    end else if (msg_sel != 2'd3) begin
      exp_push(int'(msg_sel), b);
      cnt++;
      if (cnt == 50) begin
        exp_push(int'(msg_sel), TOK);
        exp_trunc = 1'b1;
        in_msg = 1'b0;
      end
    end
  endtask

  task automatic cmp(input int ch, input logic [7:0] d);
    int sz;
    logic [7:0] e;
    checks++;
    sz = ch == 0 ? q0.size() : ch == 1 ? q1.size() : q2.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL ch%0d_unexpected actual %h required no output", ch, d);
    end else begin
      e = ch == 0 ? q0.pop_front() : ch == 1 ? q1.pop_front() : q2.pop_front();
      if (d !== e) begin
        errors++;
        $display("FAIL ch%0d_data actual %h required %h", ch, d, e);
      end
    end
    log_q.push_back('{cyc, ch, d});
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones({valid2_o, valid1_o, valid0_o}) > 1 ||
          (valid0_o !== 1'b1 && data0_o !== 8'h0) ||
          (valid1_o !== 1'b1 && data1_o !== 8'h0) ||
          (valid2_o !== 1'b1 && data2_o !== 8'h0)) begin
        errors++;
        $display("FAIL channel_exclusive actual valid %b data %h %h %h required one valid and idle data 0",
                 {valid2_o, valid1_o, valid0_o}, data0_o, data1_o, data2_o);
      end
      if (valid0_o === 1'b1) cmp(0, data0_o);
      if (valid1_o === 1'b1) cmp(1, data1_o);
      if (valid2_o === 1'b1) cmp(2, data2_o);
    end
  end

  // engine model: samples a token one edge later, then is busy for busy_len edges
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      int ch;
      ch = -1;
      if (valid0_o === 1'b1 && data0_o == TOK) ch = 0;
      else if (valid1_o === 1'b1 && data1_o == TOK) ch = 1;
      else if (valid2_o === 1'b1 && data2_o == TOK) ch = 2;
      if (ch >= 0) begin
        @(posedge clk);
        #1 busy_eng[ch] = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 busy_eng[ch] = 1'b0;
        fall_cyc[ch] = cyc;
      end
    end
  end

  function automatic int nlog(input int ch);
    int n;
    n = 0;
    foreach (log_q[i]) if (log_q[i].ch == ch) n++;
    return n;
  endfunction

  function automatic ent_t nth(input int ch, input int k);
    int n;
    ent_t r;
    n = 0;
    r = '{-1, -1, 8'h0};
    foreach (log_q[i])
      if (log_q[i].ch == ch) begin
        if (n == k) r = log_q[i];
        n++;
      end
    return r;
  endfunction

  task automatic send(input logic [7:0] b, input logic [1:0] s);
    data_i = b;
    select = s;
    valid_i = 1'b1;
    if (ready_o) model_push(b, s);
    else exp_ovf = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    data_i = '0;
  endtask

  task automatic send_str(input string s, input logic [1:0] sel);
    for (int i = 0; i < s.len(); i++) send(s[i], sel);
    send(TOK, sel);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n, quiet;
    n = 0;
    quiet = 0;
    while (quiet < 6 && n < 3000) begin
      @(posedge clk);
      #1 n++;
      quiet = (q0.size() + q1.size() + q2.size() == 0 && busy_eng == 3'b0) ? quiet + 1 : 0;
    end
    checks++;
    if (quiet < 6) begin
      errors++;
      $display("FAIL drain_timeout actual %0d bytes pending required 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", int'({valid2_o, valid1_o, valid0_o}), 0);
    chk("rst_data", int'({data2_o, data1_o, data0_o}), 0);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_flags", int'({overflow_o, trunc_o}), 0);

    log_q.delete();
    t0 = cyc + 1;
    send_str("ABC", 2'd2);
    wait_idle();
    chk("abc_count", nlog(2), 4);
    chk("abc_other_channels", nlog(0) + nlog(1), 0);
    chk("abc_first_data", int'(nth(2, 0).d), 'h41);
    chk("abc_first_latency", nth(2, 0).cyc - t0, 2);
    chk("abc_token_data", int'(nth(2, 3).d), 'hFA);
    chk("abc_token_cycle", nth(2, 3).cyc - t0, 5);

    log_q.delete();
    busy_len = 10;
    send_str("AB", 2'd2);
    send_str("CD", 2'd0);
    wait_idle();
    busy_len = 3;
    chk("b2b_ch2_count", nlog(2), 3);
    chk("b2b_ch0_count", nlog(0), 3);
    chk("b2b_ch0_first", int'(nth(0, 0).d), 'h43);
    chk("b2b_ch0_token", int'(nth(0, 2).d), 'hFA);
    chk("b2b_after_busy", int'(nth(0, 0).cyc > fall_cyc[2]), 1);

    log_q.delete();
    for (int i = 1; i <= 51; i++) send(8'(i), 2'd1);
    send(TOK, 2'd1);
    wait_idle();
    chk("trunc_count", nlog(1), 53);
    chk("trunc_last_char", int'(nth(1, 49).d), 'h32);
    chk("trunc_token", int'(nth(1, 50).d), 'hFA);
    chk("trunc_next_head", int'(nth(1, 51).d), 'h33);
    chk("trunc_flag", int'(trunc_o), int'(exp_trunc));

    log_q.delete();
    busy_force = 3'b111;
    idle(2);
    for (int m = 0; m < 2; m++) begin
      for (int i = 1; i <= 31; i++) send(8'(m * 32 + i), 2'd0);
      send(TOK, 2'd0);
    end
    chk("full_ready", int'(ready_o), 0);
    send(8'h77, 2'd0);
    chk("full_overflow", int'(overflow_o), 1);
    busy_force = 3'b000;
    wait_idle();
    chk("full_drain_count", nlog(0), 64);
    chk("full_drain_first", int'(nth(0, 0).d), 'h01);
    chk("full_drain_last", int'(nth(0, 63).d), 'hFA);
    chk("overflow_flag", int'(overflow_o), int'(exp_ovf));

    log_q.delete();
    send_str("XY", 2'd3);
    send_str("Z", 2'd0);
    wait_idle();
    chk("discard_total", log_q.size(), 2);
    chk("discard_next_data", int'(nth(0, 0).d), 'h5A);
    chk("discard_next_token", int'(nth(0, 1).d), 'hFA);

    log_q.delete();
    for (int i = 0; i < 8; i++) send(8'h61 + 8'(i), 2'd1);
    chk("mid_fwd_streaming", int'(nlog(1) > 0), 1);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    in_msg = 1'b0;
    cnt = 0;
    exp_ovf = 1'b0;
    exp_trunc = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_valid", int'({valid2_o, valid1_o, valid0_o}), 0);
    chk("mid_rst_data", int'({data2_o, data1_o, data0_o}), 0);
    chk("mid_rst_ready", int'(ready_o), 1);
    chk("mid_rst_flags", int'({overflow_o, trunc_o}), int'({exp_ovf, exp_trunc}));
    idle(5);
    log_q.delete();
    send_str("QR", 2'd0);
    wait_idle();
    chk("post_rst_count", nlog(0), 3);
    chk("post_rst_first", int'(nth(0, 0).d), 'h51);
    chk("post_rst_other", nlog(1) + nlog(2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
